// File: rtl/rob_pr_free_q_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// rob_pr_free_q_pkg : shared PR types and sizing for the ROB free queue
// Rev 1.0
// ============================================================
package rob_pr_free_q_pkg;

  localparam int ROB_PR_FREE_Q_ENTRIES = 2;
  localparam int COMMIT_LANES          = 4;
  localparam int PRF_BANK_COUNT        = 4;
  localparam int PR_COUNT              = 128;
  localparam int LOG_PR_COUNT          = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT    = $clog2(PRF_BANK_COUNT);
  localparam int UPPER_PR_W            = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef logic [LOG_PR_COUNT-1:0]       PR_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] PR_bank_t;
  typedef logic [UPPER_PR_W-1:0]         upper_PR_t;

  function automatic PR_bank_t PR_bank_bits(input PR_t pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

  function automatic upper_PR_t upper_PR_bits(input PR_t pr);
    return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_pr_free_q_bank_select.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// pq_lsb_bank_select : per-bank lowest-index lane select (one-hot + found)
// Rev 1.0
// ============================================================
module pq_lsb_bank_select #(
  parameter int LANES  = 4,
  parameter int BANKS  = 4,
  parameter int BANK_W = 2
) (
  input  logic [LANES-1:0]             mask,
  input  logic [LANES-1:0][BANK_W-1:0] lane_bank,
  output logic [BANKS-1:0][LANES-1:0]  sel,
  output logic [BANKS-1:0]             found
);

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [LANES-1:0] w_match;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign w_match[i] = mask[i] & (lane_bank[i] == BANK_W'(b));
    end
    // x & -x isolates the lowest set bit, giving ascending-lane priority
    assign sel[b]   = w_match & (~w_match + LANES'(1));
    assign found[b] = |w_match;
  end

endmodule
`default_nettype wire

// File: rtl/rob_pr_free_q.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// rob_pr_free_q : buffers commit bundles of freed PRs, drains each to its bank
// Rev 1.0
// ============================================================
module rob_pr_free_q
  import rob_pr_free_q_pkg::*;
(
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          enq_valid,
  input  logic [COMMIT_LANES-1:0]                       enq_lane_valid,
  input  logic [COMMIT_LANES-1:0][LOG_PR_COUNT-1:0]     enq_PR_by_lane,
  output logic                                          enq_ready,
  output logic [PRF_BANK_COUNT-1:0]                     free_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]     free_upper_PR_by_bank,
  input  logic [PRF_BANK_COUNT-1:0]                     free_ready_by_bank
);

  localparam int ENTRIES = ROB_PR_FREE_Q_ENTRIES;
  localparam int PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W   = $clog2(ENTRIES + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  logic [ENTRIES-1:0][COMMIT_LANES-1:0] r_mask;
  PR_t  [ENTRIES-1:0][COMMIT_LANES-1:0] r_pr;
  logic [PTR_W-1:0]                     r_enq_ptr;
  logic [PTR_W-1:0]                     r_deq_ptr;
  logic [CNT_W-1:0]                     r_count;

  logic                                           w_nonempty;
  logic                                           w_enq_fire;
  logic                                           w_deq_done;
  logic [COMMIT_LANES-1:0]                        w_head_mask;
  logic [COMMIT_LANES-1:0]                        w_clear;
  logic [COMMIT_LANES-1:0]                        w_post_mask;
  logic [COMMIT_LANES-1:0][LOG_PRF_BANK_COUNT-1:0] w_head_bank;
  logic [PRF_BANK_COUNT-1:0][COMMIT_LANES-1:0]    w_sel;
  logic [PRF_BANK_COUNT-1:0]                      w_found;
  logic [PRF_BANK_COUNT-1:0]                      w_fire;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // No same-cycle credit from a completing head: ready is purely registered
  assign w_nonempty = (r_count != '0);
  assign enq_ready  = (r_count != FULL_CNT);
  assign w_enq_fire = enq_valid & enq_ready & (|enq_lane_valid);
  assign w_head_mask = w_nonempty ? r_mask[r_deq_ptr] : '0;

  always_comb begin
    w_head_bank = '0;
    for (int i = 0; i < COMMIT_LANES; i++) begin
      w_head_bank[i] = PR_bank_bits(r_pr[r_deq_ptr][i]);
    end
  end

  pq_lsb_bank_select #(
    .LANES  (COMMIT_LANES),
    .BANKS  (PRF_BANK_COUNT),
    .BANK_W (LOG_PRF_BANK_COUNT)
  ) u_bank_select (
    .mask      (w_head_mask),
    .lane_bank (w_head_bank),
    .sel       (w_sel),
    .found     (w_found)
  );

  assign free_valid_by_bank = w_found;
  assign w_fire             = w_found & free_ready_by_bank;

  always_comb begin
    free_upper_PR_by_bank = '0;
    w_clear               = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < COMMIT_LANES; i++) begin
        if (w_sel[b][i]) begin
          free_upper_PR_by_bank[b] = upper_PR_bits(r_pr[r_deq_ptr][i]);
          w_clear[i]               = w_clear[i] | w_fire[b];
        end
      end
    end
  end

  assign w_post_mask = w_head_mask & ~w_clear;
  assign w_deq_done  = w_nonempty & (w_post_mask == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mask    <= '0;
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
      r_count   <= '0;
    end else begin
      if (w_nonempty) r_mask[r_deq_ptr] <= w_post_mask;
      if (w_enq_fire) begin
        r_mask[r_enq_ptr] <= enq_lane_valid;
        r_enq_ptr         <= next_ptr(r_enq_ptr);
      end
      if (w_deq_done) r_deq_ptr <= next_ptr(r_deq_ptr);
      case ({w_enq_fire, w_deq_done})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // PR payload needs no reset; it is only observed through a valid mask bit
  always_ff @(posedge CLK) begin
    if (w_enq_fire) r_pr[r_enq_ptr] <= enq_PR_by_lane;
  end

  a_no_enq_when_full : assert property (
    @(posedge CLK) disable iff (RST) !(enq_valid && !enq_ready)
  );

endmodule
`default_nettype wire
